// File: rtl/genius_ir_pkg.sv
// Shared types and constants for the IR remote frame decoder.
// Holds the decoder state encoding, default sample timing and the named
// button codes from which the default accept mask is built.
package genius_ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } ir_state_e;

  // Frame timing in clk_pll cycles counted from the first RUN cycle
  localparam int unsigned IR_SAMPLE_FIRST  = 193;
  localparam int unsigned IR_SAMPLE_PERIOD = 41;

  // Button codes the remote is allowed to send
  localparam logic [2:0] BTN_RED    = 3'b100;
  localparam logic [2:0] BTN_GREEN  = 3'b011;
  localparam logic [2:0] BTN_BLUE   = 3'b110;
  localparam logic [2:0] BTN_YELLOW = 3'b010;
  localparam logic [2:0] BTN_START  = 3'b001;

  // One bit per code; bit k set means code k is accepted (8'b0101_1110)
  localparam logic [7:0] IR_VALID_MASK = (8'd1 << BTN_RED)    |
                                         (8'd1 << BTN_GREEN)  |
                                         (8'd1 << BTN_BLUE)   |
                                         (8'd1 << BTN_YELLOW) |
                                         (8'd1 << BTN_START);

endpackage

// File: rtl/ir_rx_sync.sv
// Purpose : two-flop synchronizer for the IR line plus falling-edge detect.
// Latency : line change visible on rxd_s_o 2 cycles later, fall_o same cycle as rxd_s_o falls.
// Backpressure: none; free-running.
// Ports   : clk_pll, reset (sync, active-high), rxd_i (async line),
//           rxd_s_o (synchronized line), fall_o (synchronized high-to-low).
module ir_rx_sync (
  input  logic clk_pll,
  input  logic reset,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Line idles high, so reset everything to 1 to avoid a false start edge
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ir_frame_decoder.sv
// Purpose : decodes a fixed-timing IR button frame into a code, with a random
//           colour latched at frame start.
// Latency : ready/err 2 cycles after the last sample point; ack to ready low 1 cycle.
// Backpressure: ready is held until ack; start edges are ignored while busy.
// Ports   : clk_pll, reset (sync, active-high), IRDA_RXD (async line), ack;
//           cor (colour), botao (last valid code), ready (level), err (1-cycle pulse).
// Option  : define IR_MAJORITY_VOTE_EN for 2-of-3 voting around each sample point.
module ir_frame_decoder
  import genius_ir_pkg::*;
#(
  parameter int unsigned             CODE_W        = 3,
  parameter int unsigned             COR_W         = 2,
  parameter int unsigned             CNT_W         = 9,
  parameter int unsigned             SAMPLE_FIRST  = IR_SAMPLE_FIRST,
  parameter int unsigned             SAMPLE_PERIOD = IR_SAMPLE_PERIOD,
  parameter logic [2**CODE_W-1:0]    VALID_MASK    = IR_VALID_MASK
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic              IRDA_RXD,
  input  logic              ack,
  output logic [COR_W-1:0]  cor,
  output logic [CODE_W-1:0] botao,
  output logic              ready,
  output logic              err
);

  localparam logic [CNT_W-1:0] FIRST_PT = CNT_W'(SAMPLE_FIRST);
  localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] LAST_PT  = CNT_W'(SAMPLE_FIRST + (CODE_W - 1) * SAMPLE_PERIOD);

  logic rxd_s;
  logic fall;

  ir_rx_sync u_sync (
    .clk_pll (clk_pll),
    .reset   (reset),
    .rxd_i   (IRDA_RXD),
    .rxd_s_o (rxd_s),
    .fall_o  (fall)
  );

  ir_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  pt_q;     // next sample point on the frame counter
  logic [CODE_W-1:0] shreg_q;
  logic [COR_W-1:0]  col_q;
  logic [COR_W-1:0]  cor_q;
  logic [CODE_W-1:0] botao_q;
  logic              ready_q;
  logic              err_q;

  logic              bit_now;
  logic              hit;
  logic [CODE_W-1:0] code_w;

`ifdef IR_MAJORITY_VOTE_EN
  // Vote is taken one cycle after the point, once point+1 has arrived.
  // The last bit's point+1 falls in CHECK, so it is folded in there directly
  // and the RUN->CHECK timing matches the single-sample build.
  logic [1:0] hist_q;

  always_ff @(posedge clk_pll) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rxd_s};
  end

  assign bit_now = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
  assign hit     = (cnt_q == pt_q + CNT_W'(1));
  assign code_w  = {shreg_q[CODE_W-2:0], bit_now};
`else
  assign bit_now = rxd_s;
  assign hit     = (cnt_q == pt_q);
  assign code_w  = shreg_q;
`endif

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pt_q    <= '0;
      shreg_q <= '0;
      col_q   <= '0;
      cor_q   <= '0;
      botao_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          col_q <= col_q + COR_W'(1);
          if (fall) begin
            cor_q   <= col_q;
            cnt_q   <= '0;
            pt_q    <= FIRST_PT;
            shreg_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (hit) begin
            shreg_q <= {shreg_q[CODE_W-2:0], bit_now};
            pt_q    <= pt_q + PERIOD;
          end
          if (cnt_q == LAST_PT) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (VALID_MASK[code_w]) begin
            botao_q <= code_w;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cor   = cor_q;
  assign botao = botao_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Bench for ir_frame_decoder: builds each IR frame as a per-cycle line
// waveform, derives the expected code, colour and handshake timing from that
// waveform with plain arithmetic, and compares every cycle of every frame.
`timescale 1ns/1ps
module tb_ir_frame_decoder;

  localparam int CODE_W = 3;
  localparam int COR_W  = 2;
  localparam int SF     = 193;
  localparam int SP     = 41;
  localparam int LASTP  = SF + (CODE_W - 1) * SP;   // last sample count
  localparam int DONE_T = LASTP + 5;                // first ready/err cycle, from raw low cycle
  localparam logic [7:0] ACCEPT = 8'b0101_1110;

  logic              clk_pll = 1'b0;
  logic              reset   = 1'b1;
  logic              IRDA_RXD = 1'b1;
  logic              ack     = 1'b0;
  logic [COR_W-1:0]  cor;
  logic [CODE_W-1:0] botao;
  logic              ready;
  logic              err;

  always #5 clk_pll = ~clk_pll;

  ir_frame_decoder dut (
    .clk_pll  (clk_pll),
    .reset    (reset),
    .IRDA_RXD (IRDA_RXD),
    .ack      (ack),
    .cor      (cor),
    .botao    (botao),
    .ready    (ready),
    .err      (err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int idle_cyc = 0;          // IDLE cycles since last reset = colour counter value
  bit m_idle = 1'b0;
  logic [COR_W-1:0]  exp_cor   = '0;
  logic [CODE_W-1:0] exp_botao = '0;
  logic line_a [0:2047];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    if (m_idle) idle_cyc++;
    @(posedge clk_pll);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; IRDA_RXD = 1'b1; ack = 1'b0; m_idle = 1'b0;
    tick();
    check("rst_cor",   32'(cor),   0);
    check("rst_botao", 32'(botao), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_err",   32'(err),   0);
    reset = 1'b0;
    exp_cor = '0; exp_botao = '0; idle_cyc = 0; m_idle = 1'b1;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      check("idle_ready", 32'(ready), 0);
      check("idle_err",   32'(err),   0);
      check("idle_cor",   32'(cor),   32'(exp_cor));
      check("idle_botao", 32'(botao), 32'(exp_botao));
      IRDA_RXD = 1'b1; ack = 1'($urandom_range(0, 1)); m_idle = 1'b1;
      tick();
    end
  endtask

  // code: intended button; noise: random line outside sample windows;
  // gbit/gpos: flip one cycle of bit gbit's window (gpos -1/0/+1, gbit<0 none);
  // ack_at: ack rises this many cycles after the first DONE cycle (<0: high all along);
  // rst_at: assert reset at this frame count (<0 none).
  task automatic frame(input logic [CODE_W-1:0] code, input bit noise, input int gbit,
                       input int gpos, input int ack_at, input int rst_at);
    logic [CODE_W-1:0] m_code;
    logic [COR_W-1:0]  new_cor;
    bit valid;
    int ack_t, ack_rise, end_t;
    bit e_ready, e_err;
    new_cor = '0;
    for (int t = 0; t < 2048; t++) line_a[t] = 1'b1;
    if (noise) for (int t = 1; t < LASTP + 3; t++) line_a[t] = 1'($urandom_range(0, 1));
    line_a[0] = 1'b0;
    for (int i = 0; i < CODE_W; i++) begin
      int p;
      p = 1 + SF + i * SP;   // raw cycle seen at count SF+i*SP
      for (int k = -1; k <= 1; k++) line_a[p + k] = code[CODE_W - 1 - i];
      if (gbit == i) line_a[p + gpos] = ~line_a[p + gpos];
    end
    for (int i = 0; i < CODE_W; i++) begin
      int p;
      p = 1 + SF + i * SP;
`ifdef IR_MAJORITY_VOTE_EN
      m_code[CODE_W - 1 - i] = (int'(line_a[p - 1]) + int'(line_a[p]) + int'(line_a[p + 1])) >= 2;
`else
      m_code[CODE_W - 1 - i] = line_a[p];
`endif
    end
    valid    = ACCEPT[m_code];
    ack_t    = (ack_at < 0) ? DONE_T : DONE_T + ack_at;
    ack_rise = (ack_at < 0) ? 0 : DONE_T + ack_at;
    if (noise && valid) for (int t = DONE_T; t <= ack_t - 4; t++) line_a[t] = 1'($urandom_range(0, 1));
    end_t = valid ? ack_t + 2 : DONE_T + 2;

    for (int t = 0; t <= end_t; t++) begin
      if (t == 2) new_cor = COR_W'(idle_cyc);
      if (t == 3) exp_cor = new_cor;
      if (t == DONE_T && valid) exp_botao = m_code;
      e_ready = valid && t >= DONE_T && t <= ack_t;
      e_err   = !valid && t == DONE_T;
      check("frm_ready", 32'(ready), 32'(e_ready));
      check("frm_err",   32'(err),   32'(e_err));
      check("frm_cor",   32'(cor),   32'(exp_cor));
      check("frm_botao", 32'(botao), 32'(exp_botao));
      if (rst_at >= 0 && t == 3 + rst_at) begin
        reset = 1'b1; IRDA_RXD = line_a[t]; m_idle = 1'b0;
        tick();
        check("midrst_cor",   32'(cor),   0);
        check("midrst_botao", 32'(botao), 0);
        check("midrst_ready", 32'(ready), 0);
        check("midrst_err",   32'(err),   0);
        reset = 1'b0; IRDA_RXD = 1'b1; ack = 1'b0;
        exp_cor = '0; exp_botao = '0; idle_cyc = 0; m_idle = 1'b1;
        return;
      end
      IRDA_RXD = line_a[t];
      ack      = valid && t >= ack_rise;
      m_idle   = valid ? (t <= 2 || t > ack_t) : (t <= 2 || t >= DONE_T);
      tick();
    end
    ack = 1'b0;
  endtask

  initial begin
    do_reset();
    // Edge seen after 6 idle cycles, glitches on the line during RUN
    idle_check(4);
    frame(3'b110, 1'b1, -1, 0, 5, -1);
    check("first_cor", 32'(cor), 2);
    check("first_botao", 32'(botao), 32'(3'b110));
    idle_check(3);
    // Rejected code: err pulse, botao kept
    frame(3'b111, 1'b0, -1, 0, 0, -1);
    idle_check(2);
    // ack already high: ready for a single cycle
    frame(3'b011, 1'b0, -1, 0, -1, -1);
    idle_check(2);
    // Reset mid-frame, then a normal frame
    frame(3'b100, 1'b0, -1, 0, 3, 200);
    idle_check(3);
    frame(3'b010, 1'b0, -1, 0, 2, -1);
    idle_check(2);
    // Single-cycle low glitch at count 234 while the line is high
    frame(3'b110, 1'b0, 1, 0, 1, -1);
    idle_check(2);
    // ready held 1000 cycles while new edges arrive
    frame(3'b001, 1'b1, -1, 0, 1000, -1);
    idle_check(2);
    for (int f = 0; f < 10; f++) begin
      frame(CODE_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4) - 1, $urandom_range(0, 2) - 1,
            $urandom_range(0, 30), -1);
      idle_check($urandom_range(0, 5));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
